adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-bit ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained slices, one slice per clock.
- Throughput is one operation per cycle.
- Valid/ready handshakes on both sides let it sit between streaming datapath blocks with backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages and slices. Slice width SW = WIDTH/STAGES. Legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry-out of MSB. For sub=1, 1 means no borrow (A>=B unsigned).

Behaviour:
- Interface: single clock domain (clk); synchronous active-high reset rst.
- Reset, applied when rst=1 at a rising edge:
  - All stage valid bits, out_valid, sum, cout and all skew/partial-sum registers clear to 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight beat. No result for those beats is ever produced.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - While stalled, every pipeline register holds, including sum, cout and out_valid.
  - a/b/cin/sub are don't-care when in_valid=0.
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k: bits [k*SW +: SW] of A and of B' (B' = sub ? ~B : B).
  - Stage k's carry-in is the registered carry from stage k-1. Stage 0's carry-in is sub ? 1 : cin.
  - Upper operand slices travel through skew registers. Completed lower result slices travel through deskew registers, so every slice of a beat lands at the output together.
  - Latency: a beat accepted at edge N is visible on sum/cout with out_valid=1 after edge N+STAGES, provided there is no stall.
  - Back-to-back beats produce back-to-back results. Bubbles (in_valid=0) propagate as out_valid=0.
  - Simultaneous input accept and output pop in the same cycle is legal and sustains full rate.
  - STAGES=1 degenerates to a registered adder with latency 1.
- Arithmetic:
  - Wrap-around modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.
  - 0xFF+0x01 at WIDTH=8 gives sum=0x00, cout=1.
- When out_valid=0, sum/cout keep their last value. The bench must not check them then.
- Ordering: results leave in strict acceptance order. No beat is dropped or duplicated under any out_ready pattern.

Optional Feature:
- Macro: ADDER_PIPE_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of the final result.
  - ovf = carry into MSB XOR carry out of MSB, using the effective operands A and B'.
  - ovf is registered alongside sum, has the same latency, holds under stall, and resets to 0.
- Undefined: the port does not exist and no overflow logic is built.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1; a=0x02, b=0x03, cin=0, sub=0 -> sum=0x05, cout=0, out_valid high exactly 2 cycles after accept.
- a=0xFF, b=0x01, cin=0 then a=0xFF, b=0xFF, cin=1, issued back-to-back -> consecutive results 0x00/cout=1, then 0xFF/cout=1. With ADDER_PIPE_OVF_EN, ovf=0 for both.
- sub=1: a=0x05, b=0x07 -> sum=0xFE, cout=0. Then a=0x81, b=0x01 -> sum=0x80, cout=1. With the macro: a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
- Stream 8 beats a=i, b=2i with out_ready toggling 1,0,0,1,... -> in_ready low exactly while out_valid && !out_ready; outputs 0,3,6,...,21 in order, none lost or repeated.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and sum=0 next cycle; neither beat ever appears; a new beat a=0x10, b=0x20 yields 0x30 after the normal latency.
- Parameter sweep WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1 -> random stream of 1000 beats matches a reference model (a + B' + carry-in); latency 4 and 1 cycles respectively.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit add/subtract built from STAGES carry-chained
// slices of SW = WIDTH/STAGES bits, one slice per clock, valid/ready on both
// sides. Define ADDER_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module adder_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic                         stall;

  // Per-stage registers: valid, carry out of the slice just added, operand
  // skew copies (upper slices still to be added) and the growing result word.
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            cy_q, cy_d;
  logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
  logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;

  // What each stage sees at its input: the ports for stage 0, the previous
  // stage's registers otherwise.
  logic [STAGES-1:0]            src_v, src_c;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_r;
  logic [STAGES-1:0][SW:0]      slice;

  assign stall     = vld_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];

  // Route each stage's inputs; B is inverted once at entry for subtraction.
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_a    = '0;
    src_b    = '0;
    src_r    = '0;
    src_v[0] = in_valid;
    src_c[0] = sub | cin;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_r[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k] = vld_q[k-1];
      src_c[k] = cy_q[k-1];
      src_a[k] = opa_q[k-1];
      src_b[k] = opb_q[k-1];
      src_r[k] = res_q[k-1];
    end
  end

  // Slice adders: stage k adds bits [k*SW +: SW] with the chained carry.
  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
               + {{SW{1'b0}}, src_c[k]};
    end
  end

  // Advance the pipeline unless stalled; data registers only load on a valid
  // beat so the outputs keep their last value across bubbles.
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_d[k] = src_v[k];
        if (src_v[k]) begin
          cy_d[k]                = slice[k][SW];
          opa_d[k]               = src_a[k];
          opb_d[k]               = src_b[k];
          res_d[k]               = src_r[k];
          res_d[k][k*SW +: SW]   = slice[k][SW-1:0];
        end
      end
    end
  end

  // Pipeline state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
    end
  end

  // The last stage's operand copies have no consumer.
  logic unused_skew;
  assign unused_skew = ^{opa_q[STAGES-1], opb_q[STAGES-1]};

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_q, ovf_d, msb_cin;

  // Carry into the MSB recovered from its sum bit; overflow is that XOR carry out.
  always_comb begin
    msb_cin = slice[STAGES-1][SW-1] ^ src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1];
    ovf_d   = ovf_q;
    if (!stall && src_v[STAGES-1]) begin
      ovf_d = msb_cin ^ slice[STAGES-1][SW];
    end
  end

  // Overflow flag registered alongside the final result slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: three configurations (8/2, 16/4, 8/1)
// run side by side against an arithmetic reference model and a scoreboard.
module tb_adder_pipe;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input int cfg_id, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL cfg%0d %s: got %0h, expected %0h", cfg_id, name, act, req);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned W = (g == 1) ? 16 : 8;
    localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] MSB  = ONES ^ (ONES >> 1);

    typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      bit           has_lit;
      logic [W-1:0] lsum;
      logic         lcout;
      logic         lovf;
    } beat_t;

    typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      bit           has_lit;
      logic [W-1:0] lsum;
      logic         lcout;
      logic         lovf;
      int unsigned  acc_cyc;
      int unsigned  acc_stall;
    } exp_t;

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef ADDER_PIPE_OVF_EN
    logic         ovf;
`endif

    beat_t       stim[$];
    exp_t        sb[$];
    int unsigned cyc       = 0;
    int unsigned stall_cnt = 0;
    int unsigned rdy_mode  = 0;
    int unsigned gap_pct   = 0;
    bit          acc_now    = 1'b0;
    bit          front_seen = 1'b0;
    bit          rst_prev   = 1'b1;
    bit          done       = 1'b0;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
`ifdef ADDER_PIPE_OVF_EN
      .ovf       (ovf),
`endif
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
    );

    // Reference: unsigned and signed integer arithmetic on the operands.
    function automatic exp_t model(input beat_t t, input int unsigned c, input int unsigned s);
      exp_t e;
      int   ua, ub, u, sa, sb_v, r;
      ua   = int'(t.a);
      ub   = int'(t.b);
      sa   = t.a[W-1] ? ua - (1 << W) : ua;
      sb_v = t.b[W-1] ? ub - (1 << W) : ub;
      if (t.sub) begin
        u      = ua - ub;
        e.cout = (ua >= ub);
        r      = sa - sb_v;
      end else begin
        u      = ua + ub + int'(t.cin);
        e.cout = (u >= (1 << W));
        r      = sa + sb_v + int'(t.cin);
      end
      e.sum       = u[W-1:0];
      e.ovf       = (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
      e.has_lit   = t.has_lit;
      e.lsum      = t.lsum;
      e.lcout     = t.lcout;
      e.lovf      = t.lovf;
      e.acc_cyc   = c;
      e.acc_stall = s;
      return e;
    endfunction

    task automatic push(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input bit hl,
                        input logic [W-1:0] ls, input logic lc, input logic lo);
      beat_t t;
      t.a = ta; t.b = tb_v; t.cin = tc; t.sub = ts;
      t.has_lit = hl; t.lsum = ls; t.lcout = lc; t.lovf = lo;
      stim.push_back(t);
    endtask

    task automatic drain(input int unsigned limit);
      int unsigned k;
      k = 0;
      while ((stim.size() + sb.size()) != 0 && k < limit) begin
        @(posedge clk);
        k++;
      end
      chk(g, "beats outstanding after drain", stim.size() + sb.size(), 0);
    endtask

    // Driver: presents the head of the stimulus queue, drives out_ready.
    initial begin
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      forever begin
        @(posedge clk);
        cyc++;
        if (acc_now && stim.size() != 0) void'(stim.pop_front());
        #2;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 3 == 0);
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (!rst && stim.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
          in_valid = 1'b1;
          a = stim[0].a; b = stim[0].b; cin = stim[0].cin; sub = stim[0].sub;
        end else begin
          in_valid = 1'b0;
          a = W'($urandom); b = W'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
        end
      end
    end

    // Monitor / compare, sampled mid-cycle.
    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        sb.delete();
        front_seen = 1'b0;
        acc_now    = 1'b0;
      end else begin
        if (rst_prev) begin
          chk(g, "reset out_valid", out_valid, 0);
          chk(g, "reset sum", sum, 0);
          chk(g, "reset cout", cout, 0);
          chk(g, "reset in_ready", in_ready, 1);
`ifdef ADDER_PIPE_OVF_EN
          chk(g, "reset ovf", ovf, 0);
`endif
        end
        chk(g, "in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid) begin
          chk(g, "out_valid with beat outstanding", out_valid, sb.size() != 0);
          if (sb.size() != 0) begin
            e = sb[0];
            chk(g, "sum", sum, e.sum);
            chk(g, "cout", cout, e.cout);
`ifdef ADDER_PIPE_OVF_EN
            chk(g, "ovf", ovf, e.ovf);
`endif
            if (!front_seen)
              chk(g, "latency", cyc, e.acc_cyc + S + (stall_cnt - e.acc_stall));
            if (e.has_lit && !front_seen) begin
              chk(g, "model vs literal sum", e.sum, e.lsum);
              chk(g, "literal sum", sum, e.lsum);
              chk(g, "literal cout", cout, e.lcout);
`ifdef ADDER_PIPE_OVF_EN
              chk(g, "literal ovf", ovf, e.lovf);
`endif
            end
            front_seen = 1'b1;
            if (out_ready) begin
              void'(sb.pop_front());
              front_seen = 1'b0;
            end
          end
        end
        if (out_valid && !out_ready) stall_cnt++;
        acc_now = in_valid && in_ready && (stim.size() != 0);
        if (acc_now) sb.push_back(model(stim[0], cyc, stall_cnt));
      end
      rst_prev = rst;
    end

    // Test sequence.
    initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      push(W'(2), W'(3), 1'b0, 1'b0, 1'b1, W'(5), 1'b0, 1'b0);
      push(ONES, W'(1), 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
      push(ONES, ONES, 1'b1, 1'b0, 1'b1, ONES, 1'b1, 1'b0);
      push(W'(5), W'(7), 1'b1, 1'b1, 1'b1, ONES - W'(1), 1'b0, 1'b0);
      push(MSB | W'(1), W'(1), 1'b0, 1'b1, 1'b1, MSB, 1'b1, 1'b0);
      push(MSB, W'(1), 1'b0, 1'b1, 1'b1, MSB - W'(1), 1'b1, 1'b1);
      drain(200);
      rdy_mode = 1;
      for (int i = 0; i < 8; i++)
        push(W'(i), W'(2 * i), 1'b0, 1'b0, 1'b1, W'(3 * i), 1'b0, 1'b0);
      drain(200);
      rdy_mode = 0;
      push(W'(9), W'(4), 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      push(W'(7), W'(1), 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      stim.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      push(W'(16), W'(32), 1'b0, 1'b0, 1'b1, W'(48), 1'b0, 1'b0);
      drain(200);
      rdy_mode = 2;
      gap_pct  = 20;
      repeat (1000)
        push(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 1'b0);
      drain(20000);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (cfg[0].done && cfg[1].done && cfg[2].done);
      #400000;
    join_any
    chk(-1, "all configurations finished",
        {29'd0, cfg[2].done, cfg[1].done, cfg[0].done}, 32'd7);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
